// File: rtl/uart_line_monitor_pkg.sv
// Shared definitions for the UART line monitors.
// Contents:
//   pulse_state_e  states of the low-pulse measurement FSM
//   LED_CNT_W      width of the activity LED hold counter
//   EDGE_CNT_W     width of the falling-edge counter
package uart_line_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_LONG = 2'd2
  } pulse_state_e;

  localparam int LED_CNT_W  = 8;
  localparam int EDGE_CNT_W = 16;

endpackage

// File: rtl/uart_line_sync.sv
// Synchroniser and falling-edge detector for one asynchronous, idle-high line.
// Also used by the RTS/DTR monitors.
// Ports:
//   clk32m     in   system clock
//   rst        in   synchronous reset, active-high
//   line_in    in   asynchronous line
//   line_sync  out  line_in delayed by SYNC_STAGES clocks (reset value 1)
//   fall       out  one-cycle pulse when line_sync goes from 1 to 0
module uart_line_sync
  import uart_line_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk32m,
  input  logic rst,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  // Marks which chain stages hold real samples rather than reset fill.
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   prev_q, prev_d;
  // Falls are only reported once the line has been seen genuinely high
  // after reset, so a line held low through reset produces no edge.
  logic                   armed_q, armed_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], line_in};
    fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
    prev_d  = sync_q[SYNC_STAGES-1];
    armed_d = armed_q | (fill_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1]);
  end

  always_ff @(posedge clk32m) begin
    if (rst) begin
      sync_q  <= '1;
      fill_q  <= '0;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign line_sync = sync_q[SYNC_STAGES-1];
  assign fall      = armed_q & prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_line_monitor.sv
// Passive observer for one UART line (one instance per direction).
// Provides a synchronised copy of the line, a stretched active-low activity
// LED, a wrapping falling-edge count and the shortest complete low pulse.
// Ports:
//   clk32m           in   system clock, all state on its rising edge
//   rst              in   synchronous reset, active-high
//   line_in          in   asynchronous UART line, idle high
//   clear_min        in   one-cycle request to discard min_pulse
//   line_sync        out  synchronised line_in
//   activity_led     out  0 = recent traffic (LED on), 1 = LED off
//   edge_count       out  falling edges seen, modulo 2**16
//   min_pulse        out  shortest complete low pulse in clk cycles
//   min_pulse_valid  out  min_pulse holds a real measurement
module uart_line_monitor
  import uart_line_monitor_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PRESCALE_WIDTH = 18,
  parameter int LED_TIMEOUT    = 25,
  parameter int PULSE_WIDTH    = 16
) (
  input  logic                   clk32m,
  input  logic                   rst,
  input  logic                   line_in,
  input  logic                   clear_min,
  output logic                   line_sync,
  output logic                   activity_led,
  output logic [EDGE_CNT_W-1:0]  edge_count,
  output logic [PULSE_WIDTH-1:0] min_pulse,
  output logic                   min_pulse_valid
);

  logic fall;
  logic tick;
  logic capture;

  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [LED_CNT_W-1:0]      led_cnt_q, led_cnt_d;
  logic [EDGE_CNT_W-1:0]     edge_cnt_q, edge_cnt_d;
  pulse_state_e              state_q, state_d;
  logic [PULSE_WIDTH-1:0]    pcnt_q, pcnt_d;
  logic [PULSE_WIDTH-1:0]    min_q, min_d;
  logic                      min_vld_q, min_vld_d;

  uart_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk32m    (clk32m),
    .rst       (rst),
    .line_in   (line_in),
    .line_sync (line_sync),
    .fall      (fall)
  );

  assign tick = &presc_q;

  // Prescaler, LED hold counter and edge counter.
  always_comb begin
    presc_d    = presc_q + PRESCALE_WIDTH'(1);
    led_cnt_d  = led_cnt_q;
    edge_cnt_d = edge_cnt_q;
    // A fresh edge restarts the hold time even if a tick lands on the same cycle.
    if (fall) begin
      led_cnt_d = LED_CNT_W'(LED_TIMEOUT);
    end else if (tick && (led_cnt_q != '0)) begin
      led_cnt_d = led_cnt_q - LED_CNT_W'(1);
    end
    if (fall) begin
      edge_cnt_d = edge_cnt_q + EDGE_CNT_W'(1);
    end
  end

  // Pulse measurement FSM and minimum tracking.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    capture   = 1'b0;
    min_d     = min_q;
    min_vld_d = min_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_LOW;
          pcnt_d  = PULSE_WIDTH'(1);
        end
      end
      ST_LOW: begin
        if (!line_sync) begin
          // A pulse that saturates the counter is a break or a stuck line,
          // not a baud-rate sample, so it is dropped.
          if (pcnt_q == '1) begin
            state_d = ST_LONG;
          end else begin
            pcnt_d = pcnt_q + PULSE_WIDTH'(1);
          end
        end else begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_LONG: begin
        if (line_sync) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear_min) begin
      min_d     = '1;
      min_vld_d = 1'b0;
    end else if (capture && (!min_vld_q || (pcnt_q < min_q))) begin
      min_d     = pcnt_q;
      min_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk32m) begin
    if (rst) begin
      presc_q    <= '0;
      led_cnt_q  <= '0;
      edge_cnt_q <= '0;
      state_q    <= ST_IDLE;
      pcnt_q     <= '0;
      min_q      <= '1;
      min_vld_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      led_cnt_q  <= led_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      min_q      <= min_d;
      min_vld_q  <= min_vld_d;
    end
  end

  assign activity_led    = (led_cnt_q == '0);
  assign edge_count      = edge_cnt_q;
  assign min_pulse       = min_q;
  assign min_pulse_valid = min_vld_q;

endmodule
